// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } state_t;

   localparam int unsigned RETRY_W = 4;
   localparam int unsigned LOSS_W  = 8;

   // Counter width able to hold 0..max_val-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; output resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock sequencer in the refclk domain: pulses pll_rst, waits for stable lock, releases core_reset.
// Optional lock-loss counter enabled with `define PLL_SEQ_LOSS_COUNT_EN.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
   parameter int unsigned MAX_RETRIES      = 3
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               locked,
   input  logic               resync_req,
   output logic               pll_rst,
   output logic               core_reset,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  loss_cnt
);

   localparam int unsigned RST_W = cnt_w(RST_PULSE_CYC);
   localparam int unsigned STB_W = cnt_w(LOCK_STABLE_CYC);
   localparam int unsigned TMO_W = cnt_w(LOCK_TIMEOUT_CYC);

   localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_PULSE_CYC - 1);
   localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_t             state, state_d;
   logic [RST_W-1:0]   rst_cnt, rst_cnt_d;
   logic [STB_W-1:0]   stb_cnt, stb_cnt_d;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d, tmo_inc;
   logic [RETRY_W-1:0] retry_d;
   logic               pll_rst_d, core_reset_d, ready_d, fail_d;
   logic               lock_s;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (lock_s)
   );

   // State, counters and registered outputs.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PLL_RST;
         rst_cnt    <= '0;
         stb_cnt    <= '0;
         tmo_cnt    <= '0;
         retry_cnt  <= '0;
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= state_d;
         rst_cnt    <= rst_cnt_d;
         stb_cnt    <= stb_cnt_d;
         tmo_cnt    <= tmo_cnt_d;
         retry_cnt  <= retry_d;
         pll_rst    <= pll_rst_d;
         core_reset <= core_reset_d;
         ready      <= ready_d;
         fail       <= fail_d;
      end
   end

   // Timeout keeps running through STABLE so a chattering lock cannot extend it.
   assign tmo_inc = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;

   always_comb begin
      state_d   = state;
      rst_cnt_d = rst_cnt;
      stb_cnt_d = stb_cnt;
      tmo_cnt_d = tmo_cnt;
      retry_d   = retry_cnt;

      if (resync_req) begin
         state_d   = PLL_RST;
         rst_cnt_d = '0;
         stb_cnt_d = '0;
         tmo_cnt_d = '0;
         retry_d   = '0;
      end else begin
         unique case (state)
            PLL_RST: begin
               if (rst_cnt == RST_LAST) begin
                  state_d   = WAIT_LOCK;
                  rst_cnt_d = '0;
                  tmo_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               tmo_cnt_d = tmo_inc;
               if (lock_s) begin
                  state_d   = STABLE;
                  stb_cnt_d = '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  if (retry_cnt < RETRY_MAX) begin
                     state_d   = PLL_RST;
                     rst_cnt_d = '0;
                     retry_d   = retry_cnt + 1'b1;
                  end else begin
                     state_d = FAIL;
                  end
               end
            end
            STABLE: begin
               tmo_cnt_d = tmo_inc;
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (stb_cnt == STB_LAST) begin
                  state_d = RUN;
               end else begin
                  stb_cnt_d = stb_cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_d   = PLL_RST;
                  rst_cnt_d = '0;
                  retry_d   = '0;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = PLL_RST;
            end
         endcase
      end

      pll_rst_d    = (state_d == PLL_RST) || (state_d == FAIL);
      core_reset_d = (state_d != RUN);
      ready_d      = (state_d == RUN);
      fail_d       = (state_d == FAIL);
   end

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic loss_evt;

   // Lock lost while running; saturating, cleared only by rst_n.
   assign loss_evt = (state == RUN) && !lock_s && !resync_req;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt <= '0;
      end else if (loss_evt && (loss_cnt != '1)) begin
         loss_cnt <= loss_cnt + 1'b1;
      end
   end
`else
   assign loss_cnt = '0;
`endif

endmodule
